// File: rtl/cr_osf_split_pkg.sv
// Shared types for the OSF inbound splitter: stream bus, TLV header word, debug control,
// splitter state encoding and TLV classification helpers.
package cr_osf_split_pkg;

    typedef struct packed {
        logic [63:0] tdata;
        logic [1:0]  tuser;     // [0] = SOT, [1] = EOT
    } axi4s_dp_bus_t;

    typedef enum logic [4:0] {
        RQE                = 5'd0,
        CQE                = 5'd1,
        DATA               = 5'd2,
        DATA_UNK           = 5'd3,
        LZ77               = 5'd4,
        FRMD_USER_NULL     = 5'd5,
        FRMD_USER_PI16     = 5'd6,
        FRMD_USER_PI64     = 5'd7,
        FRMD_USER_VM       = 5'd8,
        FRMD_INT_APP       = 5'd9,
        FRMD_INT_SIP       = 5'd10,
        FRMD_INT_LIP       = 5'd11,
        FRMD_INT_VM        = 5'd12,
        FRMD_INT_VM_SHORT  = 5'd13
    } tlv_types_e;

    typedef enum logic [3:0] {
        RQE_SIMPLE      = 4'd1,
        RQE_COMPOUND_4K = 4'd2,
        RQE_COMPOUND_8K = 4'd3
    } rqe_frame_size_e;

    typedef struct packed {
        logic [53:0] rsvd;
        logic        last_of_command;
        logic [3:0]  frame_size;
        logic [4:0]  tlv_type;
    } tlv_word_0_t;

    typedef struct packed {
        logic [29:0] rsvd;
        logic [1:0]  rd_mode;
    } debug_ctl_t;

    typedef enum logic [1:0] {
        SPL_IDLE = 2'd0,
        SPL_DF   = 2'd1,
        SPL_PF   = 2'd2
    } osf_split_st_e;

    function automatic logic osf_tlv_is_frmd(input logic [4:0] tlv_type);
        return tlv_type inside {FRMD_USER_NULL, FRMD_USER_PI16, FRMD_USER_PI64, FRMD_USER_VM,
                                FRMD_INT_APP, FRMD_INT_SIP, FRMD_INT_LIP, FRMD_INT_VM,
                                FRMD_INT_VM_SHORT};
    endfunction

    function automatic logic osf_tlv_is_pdt(input logic [4:0] tlv_type);
        return (tlv_type == CQE) || osf_tlv_is_frmd(tlv_type);
    endfunction

endpackage

// File: rtl/cr_osf_split_stats.sv
// Saturating per-destination TLV counters and protocol error counter for the splitter.
module cr_osf_split_stats (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        df_inc,
    input  logic        pf_inc,
    input  logic        err_inc,
    output logic [31:0] tlv_df_cnt,
    output logic [31:0] tlv_pf_cnt,
    output logic [31:0] err_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tlv_df_cnt <= '0;
            tlv_pf_cnt <= '0;
            err_cnt    <= '0;
        end else begin
            if (df_inc && (tlv_df_cnt != '1)) tlv_df_cnt <= tlv_df_cnt + 32'd1;
            if (pf_inc && (tlv_pf_cnt != '1)) tlv_pf_cnt <= tlv_pf_cnt + 32'd1;
            if (err_inc && (err_cnt != '1))   err_cnt    <= err_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/cr_osf_split.sv
// OSF inbound splitter: steers whole TLVs to the data or PDT FIFO and flags frame completion.
// Statistics counters are built only when CR_OSF_SPLIT_STATS_EN is defined.
//
//   state    | meaning
//   SPL_IDLE | between TLVs, expecting SOT
//   SPL_DF   | inside a TLV bound for the data FIFO
//   SPL_PF   | inside a TLV bound for the PDT FIFO
module cr_osf_split
    import cr_osf_split_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  axi4s_dp_bus_t ib_fifo_rdata,
    input  logic          ib_fifo_empty,
    output logic          ib_fifo_rd,
    output logic          ob_data_fifo_wr,
    output axi4s_dp_bus_t ob_data_fifo_wdata,
    input  logic          ob_data_fifo_full,
    output logic          ob_pdt_fifo_wr,
    output axi4s_dp_bus_t ob_pdt_fifo_wdata,
    input  logic          ob_pdt_fifo_full,
    input  debug_ctl_t    debug_ctl_config,
    output logic          frame_done,
    output logic          proto_err,
    output logic [31:0]   tlv_df_cnt,
    output logic [31:0]   tlv_pf_cnt,
    output logic [31:0]   err_cnt
);

    localparam logic [1:0] S_IDLE = 2'(SPL_IDLE);
    localparam logic [1:0] S_DF   = 2'(SPL_DF);
    localparam logic [1:0] S_PF   = 2'(SPL_PF);

    logic [1:0]  state_q, state_d;
    logic        simp_cmd_q, cmp_cmd_q, last_frame_q, pdt_cqe_q;
    tlv_word_0_t hdr;
    logic        sot, eot, hdr_pdt, hdr_data, dst_pdt, pdt_cqe;
    logic        dst_full, dst_blocked, drop, fwd, done_hit, perr_hit;
    logic        unused_bits;

    assign hdr      = ib_fifo_rdata.tdata;
    assign sot      = ib_fifo_rdata.tuser[0];
    assign eot      = ib_fifo_rdata.tuser[1];
    assign hdr_pdt  = osf_tlv_is_pdt(hdr.tlv_type);
    assign hdr_data = hdr.tlv_type inside {DATA, DATA_UNK, LZ77};

    assign unused_bits = ^{hdr.rsvd, debug_ctl_config.rsvd};

    assign dst_pdt     = sot ? hdr_pdt : (state_q == S_PF);
    assign dst_full    = dst_pdt ? ob_pdt_fifo_full : ob_data_fifo_full;
    assign dst_blocked = dst_pdt ? (debug_ctl_config.rd_mode == 2'd2)
                                 : (debug_ctl_config.rd_mode == 2'd1);

    // Stray mid-TLV words between TLVs have no destination; they are discarded regardless of
    // backpressure. Reset gates everything so nothing moves while rst_n is low.
    assign drop = rst_n && !ib_fifo_empty && !sot && (state_q == S_IDLE);
    assign fwd  = rst_n && !ib_fifo_empty && !drop && !dst_full && !dst_blocked;

    assign ib_fifo_rd         = fwd || drop;
    assign ob_data_fifo_wr    = fwd && !dst_pdt;
    assign ob_pdt_fifo_wr     = fwd && dst_pdt;
    assign ob_data_fifo_wdata = ib_fifo_rdata;
    assign ob_pdt_fifo_wdata  = ib_fifo_rdata;

    // A single-word PDT TLV has no latched class yet, so take it from the header directly.
    assign pdt_cqe  = sot ? (hdr.tlv_type == CQE) : pdt_cqe_q;
    assign done_hit = fwd && eot && dst_pdt &&
                      ((simp_cmd_q && pdt_cqe) ||
                       (cmp_cmd_q && last_frame_q && pdt_cqe) ||
                       (cmp_cmd_q && !last_frame_q && !pdt_cqe));
    assign perr_hit = drop || (fwd && sot && (state_q != S_IDLE));

    always_comb begin
        state_d = state_q;
        if (fwd) begin
            if (eot)      state_d = S_IDLE;
            else if (sot) state_d = dst_pdt ? S_PF : S_DF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            simp_cmd_q   <= 1'b0;
            cmp_cmd_q    <= 1'b0;
            last_frame_q <= 1'b0;
            pdt_cqe_q    <= 1'b0;
            frame_done   <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_done <= done_hit;
            proto_err  <= perr_hit;
            if (fwd && sot) begin
                if (hdr.tlv_type == RQE) begin
                    simp_cmd_q <= (hdr.frame_size == RQE_SIMPLE);
                    cmp_cmd_q  <= (hdr.frame_size == RQE_COMPOUND_4K) ||
                                  (hdr.frame_size == RQE_COMPOUND_8K);
                end
                if (hdr_data) last_frame_q <= hdr.last_of_command;
                if (hdr_pdt)  pdt_cqe_q    <= (hdr.tlv_type == CQE);
            end
        end
    end

`ifdef CR_OSF_SPLIT_STATS_EN
    cr_osf_split_stats u_stats (
        .clk        (clk),
        .rst_n      (rst_n),
        .df_inc     (fwd && sot && !dst_pdt),
        .pf_inc     (fwd && sot && dst_pdt),
        .err_inc    (perr_hit),
        .tlv_df_cnt (tlv_df_cnt),
        .tlv_pf_cnt (tlv_pf_cnt),
        .err_cnt    (err_cnt)
    );
`else
    assign tlv_df_cnt = '0;
    assign tlv_pf_cnt = '0;
    assign err_cnt    = '0;
`endif

endmodule
